// File: rtl/rr_mux_arbiter_if.sv
// Shared-lane bus between four requesters and the round-robin arbiter/selector.
// master = requester side, slave = arbiter side.
interface rr_mux_arbiter_if #(
    parameter int WIDTH = 1
);
    logic [3:0]       req;
    logic [WIDTH-1:0] din0;
    logic [WIDTH-1:0] din1;
    logic [WIDTH-1:0] din2;
    logic [WIDTH-1:0] din3;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic [WIDTH-1:0] dout;
    logic             busy;

    modport master (
        output req, din0, din1, din2, din3,
        input  gnt, sel, dout, busy
    );

    modport slave (
        input  req, din0, din1, din2, din3,
        output gnt, sel, dout, busy
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter with registered 4:1 data selector onto one shared lane.
// Optional hold timeout is enabled by defining ARB_TIMEOUT_EN.
module rr_mux_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    rr_mux_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] din_sel;
    logic [3:0]       cand;
    logic [2:0]       pick_res;
    logic             win_valid;
    logic [1:0]       win;
    logic             new_grant;

`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD) + 1;
    logic [HW-1:0] hold_cnt, hold_d;
    logic          timeout;
`endif

    // Returns {valid, index} of the first set bit scanning from p upward, wrapping.
    function automatic logic [2:0] pick(input logic [3:0] c, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (c[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        case (sel_q)
            2'd0:    din_sel = bus.din0;
            2'd1:    din_sel = bus.din1;
            2'd2:    din_sel = bus.din2;
            default: din_sel = bus.din3;
        endcase
    end

    // The current holder never competes on its own release or timeout edge.
    assign cand      = (state == GRANT) ? (bus.req & ~(4'b0001 << sel_q)) : bus.req;
    assign pick_res  = pick(cand, ptr_q);
    assign win_valid = pick_res[2];
    assign win       = pick_res[1:0];

`ifdef ARB_TIMEOUT_EN
    // The edge that would make hold_cnt reach MAX_HOLD is the timeout edge.
    assign timeout = (hold_cnt >= HW'(MAX_HOLD - 1));
`endif

    always_comb begin
        state_d   = state;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        dout_d    = (state == GRANT) ? din_sel : '0;
        new_grant = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_cnt;
`endif
        case (state)
            IDLE: begin
                if (win_valid) new_grant = 1'b1;
            end
            GRANT: begin
                if (!bus.req[sel_q]) begin
                    if (win_valid) begin
                        new_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                        busy_d  = 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                end else if (timeout && win_valid) begin
                    new_grant = 1'b1;
                end else if (hold_cnt != HW'(MAX_HOLD)) begin
                    hold_d = hold_cnt + HW'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        if (new_grant) begin
            state_d = GRANT;
            gnt_d   = 4'b0001 << win;
            sel_d   = win;
            ptr_d   = win + 2'd1;
            busy_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_d  = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            gnt_q  <= 4'b0000;
            sel_q  <= 2'd0;
            ptr_q  <= 2'd0;
            busy_q <= 1'b0;
            dout_q <= '0;
        end else begin
            state  <= state_d;
            gnt_q  <= gnt_d;
            sel_q  <= sel_d;
            ptr_q  <= ptr_d;
            busy_q <= busy_d;
            dout_q <= dout_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) hold_cnt <= '0;
        else     hold_cnt <= hold_d;
    end
`endif

    assign bus.gnt  = gnt_q;
    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;
    assign bus.dout = dout_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed testbench for rr_mux_arbiter: reset, single request, rotation,
// wrap fairness, hold timeout (ARB_TIMEOUT_EN) and asynchronous mid-grant reset.
module tb_rr_mux_arbiter;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [W-1:0] dinv [4];

    rr_mux_arbiter_if #(.WIDTH(W)) bus ();

    rr_mux_arbiter #(.WIDTH(W), .MAX_HOLD(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] r, input logic [W-1:0] d0, d1, d2, d3);
        bus.req  = r;
        bus.din0 = d0;
        bus.din1 = d1;
        bus.din2 = d2;
        bus.din3 = d3;
        dinv[0] = d0;
        dinv[1] = d1;
        dinv[2] = d2;
        dinv[3] = d3;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".gnt"},  32'(bus.gnt),  32'h0);
        checkOutput({tag, ".sel"},  32'(bus.sel),  32'h0);
        checkOutput({tag, ".dout"}, 32'(bus.dout), 32'h0);
        checkOutput({tag, ".busy"}, 32'(bus.busy), 32'h0);
    endtask

    initial begin
        applyStimulus(4'b1111, 8'hA0, 8'hB1, 8'hC2, 8'hD3);

        // Reset held with all requests pending
        #1;
        checkAllZero("rst0");
        step();
        checkAllZero("rst1");
        step();
        checkAllZero("rst2");
        rst = 1'b0;

        // Rotation: each holder keeps the lane for three edges, then drops its request
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 3; c++) begin
                step();
                checkOutput($sformatf("rot%0d.gnt", k), 32'(bus.gnt), 32'(4'b0001 << k));
                checkOutput($sformatf("rot%0d.sel", k), 32'(bus.sel), 32'(k));
                checkOutput($sformatf("rot%0d.busy", k), 32'(bus.busy), 32'h1);
                if (c == 0 && k > 0)
                    checkOutput($sformatf("rot%0d.dout_prev", k), 32'(bus.dout), 32'(dinv[k-1]));
                if (c == 1)
                    checkOutput($sformatf("rot%0d.dout", k), 32'(bus.dout), 32'(dinv[k]));
            end
            bus.req[k] = 1'b0;
        end
        step();
        checkOutput("rot_end.gnt", 32'(bus.gnt), 32'h0);
        checkOutput("rot_end.busy", 32'(bus.busy), 32'h0);
        checkOutput("rot_end.sel", 32'(bus.sel), 32'h3);
        checkOutput("rot_end.dout", 32'(bus.dout), 32'hD3);
        step();
        checkOutput("rot_idle.dout", 32'(bus.dout), 32'h0);

        // Single request from requester 2 (pointer is back at 0)
        applyStimulus(4'b0100, 8'hA0, 8'hB1, 8'h01, 8'hD3);
        step();
        checkOutput("single.gnt", 32'(bus.gnt), 32'h4);
        checkOutput("single.sel", 32'(bus.sel), 32'h2);
        checkOutput("single.busy", 32'(bus.busy), 32'h1);
        step();
        checkOutput("single.dout", 32'(bus.dout), 32'h01);
        bus.req = 4'b0000;
        step();
        checkOutput("single_rel.gnt", 32'(bus.gnt), 32'h0);
        checkOutput("single_rel.sel", 32'(bus.sel), 32'h2);
        step();
        checkOutput("single_rel.dout", 32'(bus.dout), 32'h0);

        // Wrap fairness: pointer is 3, requests 3 and 0
        bus.req = 4'b1001;
        step();
        checkOutput("wrap.gnt3", 32'(bus.gnt), 32'h8);
        step();
        checkOutput("wrap.hold3", 32'(bus.gnt), 32'h8);
        bus.req = 4'b0001;
        step();
        checkOutput("wrap.gnt0", 32'(bus.gnt), 32'h1);
        checkOutput("wrap.sel0", 32'(bus.sel), 32'h0);
        bus.req = 4'b0000;
        step();
        checkOutput("wrap.idle", 32'(bus.gnt), 32'h0);
        bus.req = 4'b1111;
        step();
        checkOutput("wrap.ptr1", 32'(bus.gnt), 32'h2);
        bus.req = 4'b0000;
        step();
        checkOutput("pre_to.idle", 32'(bus.gnt), 32'h0);

        // Holder 0 keeps its request while requester 1 waits
        bus.req = 4'b0001;
        step();
        checkOutput("to.gnt0", 32'(bus.gnt), 32'h1);
        bus.req = 4'b0011;
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            step();
            checkOutput($sformatf("to.hold%0d", i), 32'(bus.gnt), 32'h1);
        end
        step();
        checkOutput("to.switch", 32'(bus.gnt), 32'h2);
        checkOutput("to.switch_sel", 32'(bus.sel), 32'h1);
`else
        for (int i = 0; i < 100; i++) begin
            step();
            checkOutput($sformatf("nto.hold%0d", i), 32'(bus.gnt), 32'h1);
        end
`endif

        // Bring requester 1 into the grant, then reset between edges
        bus.req = 4'b0010;
        step();
        checkOutput("mid.gnt1", 32'(bus.gnt), 32'h2);
        step();
        checkOutput("mid.dout1", 32'(bus.dout), 32'hB1);
        #2;
        rst = 1'b1;
        #1;
        checkAllZero("midrst");
        bus.req = 4'b1111;
        @(negedge clk);
        checkAllZero("midrst_hold");
        rst = 1'b0;
        step();
        checkOutput("post_rst.gnt", 32'(bus.gnt), 32'h1);
        checkOutput("post_rst.sel", 32'(bus.sel), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter and registered 4:1 selector that shares one output lane between four requesters. Each requester raises a request and holds it for as long as it needs the lane. The block grants one requester at a time and drives the mux select. It registers the selected data onto the shared output and rotates priority so no requester starves. It replaces ad-hoc priority if/else selection wherever several sources contend for one sink.

## Interface
- `WIDTH`, default 1: data width of each input lane and of `dout`.
- `MAX_HOLD`, default 8: maximum consecutive grant cycles when another requester is waiting. Used only with `ARB_TIMEOUT_EN`. Must be ≥ 2.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input 4: request per requester. Bit i is requester i.
- `din0`..`din3` input WIDTH each: data of requesters 0..3.
- `gnt` output 4: one-hot grant. All zeros when no requester is granted. Registered.
- `sel` output 2: index of the granted requester. Holds its last value when `gnt`=0. Registered.
- `dout` output WIDTH: registered shared data.
- `busy` output 1: equals |`gnt`. Registered.

## Operation
**States:**
- IDLE: `gnt`=0.
- GRANT: exactly one `gnt` bit is set.

**Round-robin pointer `ptr`** (2 bits, reset 0):
- The winner is the first set `req` bit scanning `ptr`, `ptr`+1, … mod 4.
- On every new grant to index k, `ptr` becomes k+1 mod 4.

**IDLE:**
- If `req`≠0 at a clock edge, load the winner into `gnt`/`sel` and go to GRANT.
- Otherwise stay in IDLE.

**GRANT, holder h = `sel`:**
- **Release:** `req[h]`=0 at an edge.
  - If other requests are pending, grant the next winner on the same edge. There is no idle cycle between grants.
  - If none are pending, go to IDLE with `gnt`=0.
- **Hold:** `req[h]`=1 at an edge. The grant stays with h, subject to the timeout rule below.
- The holder's own `req` bit is excluded from arbitration on a release or timeout edge.

**`dout`:**
- Each edge: `dout` <= `din[sel]` if in GRANT, else 0.
- `dout` reflects the holder's data one cycle after `gnt`/`sel`.

**Hold counter `hold_cnt`:**
- Width $clog2(MAX_HOLD)+1.
- Cleared on every new grant.
- Increments each cycle a grant is held. Saturates at MAX_HOLD.

**Simultaneous events:**
- Release and new requests on the same edge: the new requests participate in the arbitration.
- A requester dropping `req` while not granted has no effect.

**Reset:**
- Asserting `rst` at any time immediately clears `gnt`, `sel`, `dout`, `busy`, `ptr` and `hold_cnt` to 0, and forces IDLE.
- A grant in progress is abandoned with no completion.

## Timing
- Request to grant: `req` high before edge N gives `gnt`/`sel`/`busy` valid after edge N. Latency is 1 cycle.
- Grant to data: `dout` = `din[sel]` after edge N+1.
- Release to next grant: 1 edge, with no gap cycle.
- Release to IDLE: `gnt`=0 after the release edge. `dout`=0 one edge later.
- Reset values: all outputs 0.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - When `hold_cnt` reaches MAX_HOLD and any other `req` bit is set, the grant is revoked on that edge. The next round-robin winner is granted on the same edge.
  - The holder keeps its `req` high and re-competes normally.
  - With no other requester pending, the grant persists indefinitely.
- Not defined:
  - The timeout logic and `hold_cnt` are compiled out.
  - A holder keeps the grant until it drops `req`. `MAX_HOLD` is ignored.

## Test plan
- **Reset:** assert `rst` with `req`=4'b1111 → `gnt`=0, `sel`=0, `dout`=0, `busy`=0 throughout. Release reset → first grant goes to requester 0.
- **Single request:** `req`=4'b0100, `din2`=1 → after 1 edge `gnt`=4'b0100, `sel`=2, `busy`=1. After 2 edges `dout`=1. Drop `req[2]` → `gnt`=0 after next edge.
- **Rotation:** `req`=4'b1111 from reset, each holder drops its `req` 3 cycles after its grant → grant order 0,1,2,3, with no cycle where `gnt`=0 between grants.
- **Fairness after wrap:** `ptr`=3 with `req`=4'b1001 → requester 3 granted, then 0 on release. `ptr` ends at 1.
- **Timeout** (`ARB_TIMEOUT_EN`, MAX_HOLD=8): `req[0]` held, `req[1]` raised during grant 0 → `gnt` switches to 4'b0010 after `gnt[0]` has been high 8 cycles. Without the macro, `gnt` stays 4'b0001 for 100 cycles.
- **Mid-grant reset:** assert `rst` asynchronously between edges while `gnt`=4'b0010 → all outputs 0 before the next edge. After release, requester 0 has priority again.
